// File: rtl/ace_snoop_ctrl_pkg.sv
// ace_snoop_ctrl_pkg: shared types and constants for the ACE snoop controller
package ace_snoop_ctrl_pkg;

    typedef enum logic [1:0] {IDLE, LOOKUP, RESP, DATA} state_e;

    localparam logic [3:0] SNP_READ_ONCE       = 4'b0000;
    localparam logic [3:0] SNP_READ_SHARED     = 4'b0001;
    localparam logic [3:0] SNP_READ_CLEAN      = 4'b0010;
    localparam logic [3:0] SNP_READ_NSD        = 4'b0011;
    localparam logic [3:0] SNP_READ_UNIQUE     = 4'b0111;
    localparam logic [3:0] SNP_CLEAN_SHARED    = 4'b1000;
    localparam logic [3:0] SNP_CLEAN_INVALID   = 4'b1001;
    localparam logic [3:0] SNP_MAKE_INVALID    = 4'b1101;
    localparam logic [3:0] SNP_DVM_COMPLETE    = 4'b1110;
    localparam logic [3:0] SNP_DVM_MESSAGE     = 4'b1111;

    localparam int CR_DATA_TRANSFER = 0;
    localparam int CR_ERROR         = 1;
    localparam int CR_PASS_DIRTY    = 2;
    localparam int CR_IS_SHARED     = 3;
    localparam int CR_WAS_UNIQUE    = 4;

    function automatic int calc_beats(input int data_width, input int line_log2);
        return (8 << line_log2) / data_width;
    endfunction

endpackage

// File: rtl/ace_snoop_cd_counter.sv
// ace_snoop_cd_counter: CD beat counter with clear, wrap on the last handshake and last-beat flag
module ace_snoop_cd_counter #(
    parameter int BEATS = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic inc_i,
    output logic last_o
);

    localparam int CW = BEATS > 1 ? $clog2(BEATS) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    assign last_o = cnt_q == CW'(BEATS - 1);

    always_comb cnt_d = (clr_i || (inc_i && last_o)) ? '0 : inc_i ? cnt_q + CW'(1) : cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;

endmodule

// File: rtl/ace_snoop_ctrl.sv
// ace_snoop_ctrl: master-side ACE snoop sequencer AC -> lookup -> CR -> CD, one snoop at a time.
// Define ACE_SNOOP_CTRL_DVM_EN to answer DVM snoops directly without a cache lookup.
module ace_snoop_ctrl
    import ace_snoop_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH       = 64,
    parameter int SNOOP_DATA_WIDTH = 128,
    parameter int CACHE_LINE_SIZE  = 6
) (
    input  logic                        ACLK,
    input  logic                        ARESETn,
    input  logic                        ACVALID,
    output logic                        ACREADY,
    input  logic [ADDR_WIDTH-1:0]       ACADDR,
    input  logic [3:0]                  ACSNOOP,
    input  logic [2:0]                  ACPROT,
    output logic                        CRVALID,
    input  logic                        CRREADY,
    output logic [4:0]                  CRRESP,
    output logic                        CDVALID,
    input  logic                        CDREADY,
    output logic [SNOOP_DATA_WIDTH-1:0] CDDATA,
    output logic                        CDLAST,
    output logic                        lk_valid,
    output logic [ADDR_WIDTH-1:0]       lk_addr,
    output logic [3:0]                  lk_snoop,
    output logic [2:0]                  lk_prot,
    input  logic                        lk_ready,
    input  logic [4:0]                  lk_resp,
    input  logic                        rd_valid,
    output logic                        rd_ready,
    input  logic [SNOOP_DATA_WIDTH-1:0] rd_data
);

    localparam int BEATS = calc_beats(SNOOP_DATA_WIDTH, CACHE_LINE_SIZE);

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [3:0]              snoop_q;
    logic [2:0]              prot_q;
    logic [4:0]              resp_q;
    logic                    is_dvm, in_data, last_beat;
    logic                    ac_hs, lk_hs, cd_hs;

`ifdef ACE_SNOOP_CTRL_DVM_EN
    assign is_dvm = ACSNOOP == SNP_DVM_COMPLETE || ACSNOOP == SNP_DVM_MESSAGE;
`else
    assign is_dvm = 1'b0;
`endif

    assign ac_hs = ACVALID && ACREADY;
    assign lk_hs = lk_valid && lk_ready;
    assign cd_hs = CDVALID && CDREADY;

    always_ff @(posedge ACLK or negedge ARESETn)
        if (!ARESETn) state_q <= IDLE;
        else          state_q <= state_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = ACVALID ? (is_dvm ? RESP : LOOKUP) : IDLE;
            LOOKUP:  state_d = lk_ready ? RESP : LOOKUP;
            RESP:    state_d = CRREADY ? (resp_q[CR_DATA_TRANSFER] ? DATA : IDLE) : RESP;
            DATA:    state_d = (cd_hs && last_beat) ? IDLE : DATA;
        endcase
    end

    always_comb begin
        in_data  = state_q == DATA;
        ACREADY  = state_q == IDLE;
        lk_valid = state_q == LOOKUP;
        CRVALID  = state_q == RESP;
        CDVALID  = in_data && rd_valid;
        rd_ready = in_data && CDREADY;
        CDDATA   = in_data ? rd_data : '0;
        CDLAST   = in_data && last_beat;
    end

    // DVM snoops bypass the lookup, so their response is forced to all-clear here
    always_ff @(posedge ACLK or negedge ARESETn)
        if (!ARESETn) begin
            addr_q  <= '0;
            snoop_q <= '0;
            prot_q  <= '0;
            resp_q  <= '0;
        end else begin
            if (ac_hs) begin
                addr_q  <= ACADDR;
                snoop_q <= ACSNOOP;
                prot_q  <= ACPROT;
            end
            if (ac_hs && is_dvm) resp_q <= '0;
            else if (lk_hs)      resp_q <= lk_resp;
        end

    assign lk_addr  = addr_q;
    assign lk_snoop = snoop_q;
    assign lk_prot  = prot_q;
    assign CRRESP   = resp_q;

    ace_snoop_cd_counter #(.BEATS(BEATS)) u_cnt (
        .clk_i  (ACLK),
        .rst_ni (ARESETn),
        .clr_i  (!in_data),
        .inc_i  (cd_hs),
        .last_o (last_beat)
    );

endmodule

// File: tb/tb_ace_snoop_ctrl.sv
// tb_ace_snoop_ctrl: directed and randomized bench with a transaction-level snoop model.
// Honours ACE_SNOOP_CTRL_DVM_EN when the build defines it.
module tb_ace_snoop_ctrl;

    localparam int BEATS = (8 << 6) / 128;
`ifdef ACE_SNOOP_CTRL_DVM_EN
    localparam bit DVM = 1'b1;
`else
    localparam bit DVM = 1'b0;
`endif

    logic ACLK = 1'b0, ARESETn = 1'b0;
    always #5 ACLK = ~ACLK;

    logic         ACVALID, ACREADY, CRVALID, CRREADY, CDVALID, CDREADY, CDLAST;
    logic [63:0]  ACADDR, lk_addr;
    logic [3:0]   ACSNOOP, lk_snoop;
    logic [2:0]   ACPROT, lk_prot;
    logic [4:0]   CRRESP, lk_resp;
    logic [127:0] CDDATA, rd_data;
    logic         lk_valid, lk_ready, rd_valid, rd_ready;

    logic         w_acvalid, w_acready, w_crvalid, w_crready, w_cdvalid, w_cdready, w_cdlast;
    logic [63:0]  w_acaddr, w_lk_addr;
    logic [3:0]   w_acsnoop, w_lk_snoop;
    logic [2:0]   w_acprot, w_lk_prot;
    logic [4:0]   w_crresp, w_lk_resp;
    logic [511:0] w_cddata, w_rd_data;
    logic         w_lk_valid, w_lk_ready, w_rd_valid, w_rd_ready;

    ace_snoop_ctrl dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .ACVALID(ACVALID), .ACREADY(ACREADY), .ACADDR(ACADDR), .ACSNOOP(ACSNOOP), .ACPROT(ACPROT),
        .CRVALID(CRVALID), .CRREADY(CRREADY), .CRRESP(CRRESP),
        .CDVALID(CDVALID), .CDREADY(CDREADY), .CDDATA(CDDATA), .CDLAST(CDLAST),
        .lk_valid(lk_valid), .lk_addr(lk_addr), .lk_snoop(lk_snoop), .lk_prot(lk_prot),
        .lk_ready(lk_ready), .lk_resp(lk_resp),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data)
    );

    ace_snoop_ctrl #(.SNOOP_DATA_WIDTH(512), .CACHE_LINE_SIZE(6)) dut_w (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .ACVALID(w_acvalid), .ACREADY(w_acready), .ACADDR(w_acaddr), .ACSNOOP(w_acsnoop), .ACPROT(w_acprot),
        .CRVALID(w_crvalid), .CRREADY(w_crready), .CRRESP(w_crresp),
        .CDVALID(w_cdvalid), .CDREADY(w_cdready), .CDDATA(w_cddata), .CDLAST(w_cdlast),
        .lk_valid(w_lk_valid), .lk_addr(w_lk_addr), .lk_snoop(w_lk_snoop), .lk_prot(w_lk_prot),
        .lk_ready(w_lk_ready), .lk_resp(w_lk_resp),
        .rd_valid(w_rd_valid), .rd_ready(w_rd_ready), .rd_data(w_rd_data)
    );

    int checks = 0, errors = 0;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Model: one outstanding snoop record and how far it has progressed
    logic        m_pend, m_looked, m_cr_done, ac_hs, rd_hs;
    logic [63:0] m_addr;
    logic [3:0]  m_snoop;
    logic [2:0]  m_prot;
    logic [4:0]  m_resp;
    int          m_beat;
    logic        e_acr, e_lkv, e_crv, e_data, e_cdv, e_rdr, e_last;

    assign e_acr  = !m_pend;
    assign e_lkv  = m_pend && !m_looked;
    assign e_crv  = m_pend && m_looked && !m_cr_done;
    assign e_data = m_pend && m_cr_done;
    assign e_cdv  = e_data && rd_valid;
    assign e_rdr  = e_data && CDREADY;
    assign e_last = e_data && m_beat == BEATS - 1;

    always @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            m_pend <= 1'b0; m_looked <= 1'b0; m_cr_done <= 1'b0; m_beat <= 0;
            m_resp <= '0; ac_hs <= 1'b0; rd_hs <= 1'b0;
        end else begin
            ac_hs <= e_acr && ACVALID;
            rd_hs <= e_cdv && CDREADY;
            if (!m_pend) begin
                if (ACVALID) begin
                    m_pend <= 1'b1; m_addr <= ACADDR; m_snoop <= ACSNOOP; m_prot <= ACPROT;
                    m_looked <= DVM && (ACSNOOP inside {4'hE, 4'hF});
                    m_resp <= '0; m_cr_done <= 1'b0; m_beat <= 0;
                end
            end else if (!m_looked) begin
                if (lk_ready) begin m_looked <= 1'b1; m_resp <= lk_resp; end
            end else if (!m_cr_done) begin
                if (CRREADY) begin
                    if (m_resp[0]) m_cr_done <= 1'b1;
                    else m_pend <= 1'b0;
                end
            end else if (rd_valid && CDREADY) begin
                if (m_beat == BEATS - 1) m_pend <= 1'b0;
                else m_beat <= m_beat + 1;
            end
        end
    end

    logic [8:0] cd_log[$];

    always @(negedge ACLK) begin
        chk("ctl", {ACREADY, lk_valid, CRVALID, CDVALID, rd_ready, CDLAST},
                   {e_acr, e_lkv, e_crv, e_cdv, e_rdr, e_last});
        if (e_lkv) chk("lk_req", {lk_addr, lk_snoop, lk_prot}, {m_addr, m_snoop, m_prot});
        if (e_crv) chk("crresp", CRRESP, m_resp);
        if (e_cdv) chk("cddata", CDDATA, rd_data);
        if (CDVALID && CDREADY) cd_log.push_back({CDDATA[7:0], CDLAST});
    end

    task automatic run_line(input logic [3:0] snp, input logic [4:0] rsp, input logic [7:0] base,
                            input int cr_hold, input bit toggle, input int abort_at);
        int n = 0, cyc = 0;
        ACVALID = 1'b1; ACADDR = {56'h0, base}; ACSNOOP = snp; ACPROT = 3'b010;
        lk_ready = 1'b1; lk_resp = rsp; CRREADY = cr_hold == 0; CDREADY = 1'b1;
        rd_valid = 1'b1; rd_data = {120'h0, base};
        do begin
            @(posedge ACLK); #1;
            cyc++;
            if (ac_hs) ACVALID = 1'b0;
            if (rd_hs) begin n++; rd_data = {120'h0, 8'(base + n)}; end
            if (n == BEATS) rd_valid = 1'b0;
            CRREADY = cyc >= cr_hold;
            if (toggle) CDREADY = ~CDREADY;
            if (abort_at != 0 && n == abort_at) break;
        end while ((ACVALID || m_pend) && cyc < 100);
        rd_valid = 1'b0;
        chk("line_timeout", cyc < 100, 1);
    endtask

    task automatic chk_log(input logic [7:0] base, input int nb);
        chk("log_len", cd_log.size(), nb);
        for (int i = 0; i < cd_log.size(); i++)
            chk("log_beat", cd_log[i], {8'(base + i), i == nb - 1});
    endtask

    initial begin
        ACVALID = 0; ACADDR = 0; ACSNOOP = 0; ACPROT = 0; CRREADY = 0; CDREADY = 0;
        lk_ready = 0; lk_resp = 0; rd_valid = 0; rd_data = 0;
        w_acvalid = 0; w_acaddr = 0; w_acsnoop = 0; w_acprot = 0; w_crready = 0; w_cdready = 0;
        w_lk_ready = 0; w_lk_resp = 0; w_rd_valid = 0; w_rd_data = 0;
        repeat (3) @(posedge ACLK);
        #1 ARESETn = 1'b1;
        @(negedge ACLK);
        chk("reset_acready", ACREADY, 1);
        chk("reset_outs", {lk_valid, CRVALID, CDVALID, rd_ready, CDLAST, CRRESP}, 0);

        // ReadShared, immediate lookup, no data
        @(posedge ACLK); #1;
        ACVALID = 1; ACADDR = 64'h1000; ACSNOOP = 4'b0001; ACPROT = 0;
        lk_ready = 1; lk_resp = 0; CRREADY = 1; CDREADY = 1;
        @(posedge ACLK); #1 ACVALID = 0;
        @(negedge ACLK);
        chk("rs_lkv_n1", lk_valid, 1);
        chk("rs_lkaddr", lk_addr, 64'h1000);
        chk("rs_crv_n1", CRVALID, 0);
        @(negedge ACLK);
        chk("rs_crv_n2", CRVALID, 1);
        chk("rs_crresp", CRRESP, 0);
        @(negedge ACLK);
        chk("rs_acready", ACREADY, 1);
        chk("rs_no_cd", CDVALID, 0);

        cd_log.delete();
        run_line(4'b1000, 5'b00101, 8'hA0, 0, 1'b0, 0);
        chk_log(8'hA0, 4);

        cd_log.delete();
        run_line(4'b0111, 5'b01101, 8'hB0, 7, 1'b1, 0);
        chk_log(8'hB0, 4);

        // Reset in the middle of a line
        cd_log.delete();
        run_line(4'b1001, 5'b00011, 8'hD0, 0, 1'b0, 2);
        ARESETn = 0; ACVALID = 0; rd_valid = 0;
        @(negedge ACLK);
        chk("rst_mid_beats", cd_log.size(), 2);
        chk("rst_mid_acready", ACREADY, 1);
        chk("rst_mid_outs", {lk_valid, CRVALID, CDVALID, rd_ready, CDLAST, CRRESP}, 0);
        @(posedge ACLK); #1 ARESETn = 1;
        @(negedge ACLK);
        chk("rst_rel_acready", ACREADY, 1);
        cd_log.delete();
        run_line(4'b0001, 5'b00001, 8'hC0, 0, 1'b0, 0);
        chk_log(8'hC0, 4);

        // DVMMessage
        @(posedge ACLK); #1;
        ACVALID = 1; ACSNOOP = 4'b1111; lk_ready = 0; lk_resp = 5'b10101; CRREADY = 0;
        @(posedge ACLK); #1 ACVALID = 0;
        @(negedge ACLK);
        if (DVM) begin
            chk("dvm_lkv", lk_valid, 0);
            chk("dvm_crv", CRVALID, 1);
            chk("dvm_crresp", CRRESP, 0);
        end else begin
            chk("dvm_lkv", lk_valid, 1);
            chk("dvm_crv", CRVALID, 0);
        end
        lk_ready = 1; CRREADY = 1; CDREADY = 1; rd_valid = 1;
        for (int i = 0; i < 20 && !ACREADY; i++) @(negedge ACLK);
        chk("dvm_timeout", ACREADY, 1);
        rd_valid = 0;

        // Randomized traffic with occasional asynchronous resets
        repeat (3000) begin
            @(posedge ACLK); #1;
            if (!ARESETn) ARESETn = 1;
            else if ($urandom_range(0, 399) == 0) begin ARESETn = 0; ACVALID = 0; rd_valid = 0; end
            if (ARESETn) begin
                if (!ACVALID || ac_hs) begin
                    ACVALID = $urandom_range(0, 2) == 0;
                    ACADDR = {$urandom, $urandom}; ACSNOOP = 4'($urandom); ACPROT = 3'($urandom);
                end
                if (!rd_valid || rd_hs) begin
                    rd_valid = $urandom_range(0, 3) != 0;
                    rd_data = {$urandom, $urandom, $urandom, $urandom};
                end
            end
            lk_ready = 1'($urandom); lk_resp = 5'($urandom);
            CRREADY = 1'($urandom); CDREADY = 1'($urandom);
        end
        @(posedge ACLK); #1 ARESETn = 0; ACVALID = 0; rd_valid = 0;
        @(posedge ACLK); #1 ARESETn = 1;

        // Single-beat line on the 512-bit instance
        w_acvalid = 1; w_acaddr = 64'h2000; w_acsnoop = 4'b1000; w_lk_ready = 1; w_lk_resp = 5'b00001;
        w_crready = 1; w_cdready = 1; w_rd_valid = 1; w_rd_data = {16{32'hDEADBEEF}};
        @(posedge ACLK); #1 w_acvalid = 0;
        @(negedge ACLK);
        chk("w_lkv", w_lk_valid, 1);
        @(negedge ACLK);
        chk("w_crv", {w_crvalid, w_crresp}, {1'b1, 5'b00001});
        @(negedge ACLK);
        chk("w_cd", {w_cdvalid, w_cdlast}, 2'b11);
        chk("w_cddata", w_cddata, {16{32'hDEADBEEF}});
        @(negedge ACLK);
        chk("w_done", {w_acready, w_cdvalid}, 2'b10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1);
    end

endmodule
